// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    count;
  logic             accept;
  logic             last;
  logic             sub_eff;
  logic [1:0]       fa;

  // Returns {carry_out, sum_bit} of a single full-adder stage.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign fa = full_add(op_a[0], op_b[0], carry);

  // Next-state logic and the start/last-bit qualifiers.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = (count == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register with registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Operand capture and one-bit-per-cycle datapath; subtraction stores ~b with carry 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= {WIDTH{1'b0}};
      op_b  <= {WIDTH{1'b0}};
      carry <= 1'b0;
      count <= {CW{1'b0}};
      sum   <= {WIDTH{1'b0}};
      cout  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub_eff ? ~b : b;
      carry <= sub_eff ? 1'b1 : cin;
      count <= {CW{1'b0}};
      sum   <= {WIDTH{1'b0}};
    end else if (state == RUN) begin
      op_a  <= {1'b0, op_a[WIDTH-1:1]};
      op_b  <= {1'b0, op_b[WIDTH-1:1]};
      carry <= fa[1];
      sum   <= {fa[0], sum[WIDTH-1:1]};
      if (last) begin
        count <= {CW{1'b0}};
        cout  <= fa[1];
      end else begin
        count <= count + CW'(1);
      end
    end else begin
      count <= count;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed and random operations
// checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Reference: plain (W+1)-bit arithmetic, {cout, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    if (s) model = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
    else   model = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
  endtask

  // One full operation; optional mid-RUN start pulse with a=0xFF that must be ignored.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input logic ts, input bit poke, input string tag);
    logic [W:0] exp;
    exp   = model(ta, tb_v, tc, ts);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    cin   = tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = ts;
`endif
    tick();
    start = 1'b0;
    scramble();
    for (int i = 0; i < W; i++) begin
      check({tag, "_busy"}, {62'd0, busy, done}, {62'd0, 1'b1, 1'b0});
      if (i == 0) check({tag, "_sum_clr"}, {56'd0, sum}, 64'd0);
      if (poke && i == 2) begin
        start = 1'b1;
        a     = 8'hFF;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, "_done"}, {62'd0, busy, done}, {62'd0, 1'b0, 1'b1});
    check({tag, "_result"}, {55'd0, cout, sum}, {55'd0, exp});
    tick();
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    check({tag, "_hold"}, {55'd0, cout, sum}, {55'd0, exp});
  endtask

  initial begin
    logic [W:0] exp;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    @(negedge clk);
    tick();
    check("reset_outputs", {53'd0, busy, done, cout, sum}, 64'd0);
    rst = 1'b0;
    tick();
    check("idle_no_start", {62'd0, busy, done}, 64'd0);

    do_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "zero");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "ff_p1");
    do_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, "a5_5a_c");
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, "restart_ignored");

    // Back-to-back with start held high: one result every W+1 cycles.
    exp   = model(8'h80, 8'h80, 1'b0, 1'b0);
    start = 1'b1;
    a     = 8'h80;
    b     = 8'h80;
    cin   = 1'b0;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < W; i++) begin
        check("b2b_busy", {62'd0, busy, done}, {62'd0, 1'b1, 1'b0});
        tick();
      end
      check("b2b_done", {62'd0, busy, done}, {62'd0, 1'b0, 1'b1});
      check("b2b_result", {55'd0, cout, sum}, {55'd0, exp});
      if (r == 2) start = 1'b0;
      tick();
    end
    check("b2b_end_idle", {62'd0, busy, done}, 64'd0);

    // Reset during RUN cycle 4 discards the partial result.
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    cin   = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrun_reset", {53'd0, busy, done, cout, sum}, 64'd0);
    rst = 1'b0;
    tick();
    check("post_reset_idle", {53'd0, busy, done, cout, sum}, 64'd0);
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, "after_reset");

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, "sub_borrow");
    do_op(8'h07, 8'h05, 1'b1, 1'b1, 1'b0, "sub_noborrow");
`endif

    for (int k = 0; k < 20; k++) begin
`ifdef SERIAL_ADDER_SUB_EN
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), bit'($urandom), "random");
`else
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, bit'($urandom), "random");
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
